muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the EX stage, parallel to the ALU. It takes the same forwarded SrcA/SrcB operands and a funct3 code. It produces a 32-bit result, which the EX/MEM input mux selects in place of ALUResult for M-extension instructions. While the unit is busy, the hazard unit stalls IF/ID/EX, using busy/done as the handshake.

Parameters:
DATA_WIDTH, 32, operand/result width; the RTL supports only 32 (the iteration counter is sized by $clog2(DATA_WIDTH)+1).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE or DONE
Funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
SrcA  input  DATA_WIDTH  rs1 operand (dividend / multiplicand)
SrcB  input  DATA_WIDTH  rs2 operand (divisor / multiplier)
flush  input  1  abort the current operation (branch mispredict or pipeline flush)
busy  output  1  high while iterating
done  output  1  one-cycle pulse; Result is valid
Result  output  DATA_WIDTH  registered result; held until the next accepted start

Behaviour:
- Reset, sampled at a clock edge: state IDLE, busy=0, done=0, Result=0, counter=0. Reset mid-operation abandons the operation; no done is produced.
- States:
  - IDLE: start accepted -> MUL or DIV (by Funct3[2]), or directly -> DONE for special divide cases.
  - MUL/DIV: counter runs 0..31, one iteration per cycle; after the 32nd iteration -> DONE.
  - DONE: done=1 for one cycle, then -> IDLE; a start in DONE is accepted as if in IDLE.
- Timing: start sampled in cycle 0. busy=1 in cycles 1..32. done=1 and Result valid in cycle 33. busy=0 in DONE.
- start while busy is ignored; operands and Funct3 are latched only on acceptance.
- flush has priority over start and over iteration: any state -> IDLE next edge, done=0, Result unchanged.
- Multiply:
  - Operands are converted to magnitudes according to signedness: MULH signed×signed, MULHSU signed×unsigned, MULHU and MUL unsigned magnitudes.
  - 32-step shift-add produces a 64-bit product; negate the product if the sign flag is set.
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- Divide:
  - 32-step restoring division on magnitudes (signed for DIV/REM).
  - Quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
- Special cases (DONE in cycle 1, no iteration):
  - Divide by zero: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU remainder = SrcA.
  - Signed overflow (SrcA=0x80000000, SrcB=0xFFFFFFFF) for DIV/REM: quotient 0x80000000, remainder 0.
- Result and done are registered outputs; there is no combinational path from inputs to outputs.

Decomposition:
- Package muldiv_pkg holds:
  - funct3 enum: MUL_OP, MULH_OP, MULHSU_OP, MULHU_OP, DIV_OP, DIVU_OP, REM_OP, REMU_OP
  - state enum: IDLE, MUL, DIV, DONE
  - constant ITERATIONS=32
- No sub-module. Multiply and divide share the accumulator, shift register and counter, so a single module is natural. Sign-fix logic is a package function, abs_and_sign.

Test Plan:
1. MUL with SrcA=7, SrcB=0xFFFFFFFD, start in cycle 0 -> busy high in cycles 1-32; done in cycle 33 only; Result=0xFFFFFFEB.
2. Upper-half multiplies, each with Result at done:
   - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE
   - MULH same operands -> 0x00000000
   - MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF
3. Divides:
   - DIV -7/2 -> 0xFFFFFFFD
   - REM -7/2 -> 0xFFFFFFFF
   - DIVU 100/7 -> 14
   - REMU 100/7 -> 2
   - each done in cycle 33
4. Special divide cases:
   - DIV 5/0 -> 0xFFFFFFFF with done in cycle 1
   - REMU 5/0 -> 5
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000
   - REM same operands -> 0
5. Control handshake:
   - start with different operands in cycle 5 is ignored; the original result appears in cycle 33.
   - flush in cycle 10 -> busy=0 in cycle 11; no done pulse; Result keeps its previous value.
   - back-to-back: start held high in the DONE cycle -> second operation's done arrives 33 cycles later.
6. reset asserted in cycle 15 of a DIV -> cycle 16: busy=0, done=0, Result=0; a new MUL 3×4 then returns 12.

Source files
------------

// File: rtl/muldiv_pkg.sv
// ----------------------------------------------------------------------------
// muldiv_pkg
//   Shared types and helpers for the iterative RV32M multiply/divide unit.
//   - funct3_e    : M-extension operation encodings (instruction funct3 field)
//   - state_e     : sequencer states
//   - ITERATIONS  : shift-add / restoring-divide step count
//   - abs_and_sign: magnitude + sign extraction used before iterating
// ----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int ITERATIONS = 32;

    typedef enum logic [2:0] {
        MUL_OP    = 3'b000,
        MULH_OP   = 3'b001,
        MULHSU_OP = 3'b010,
        MULHU_OP  = 3'b011,
        DIV_OP    = 3'b100,
        DIVU_OP   = 3'b101,
        REM_OP    = 3'b110,
        REMU_OP   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic        neg;
        logic [31:0] mag;
    } abs_sign_t;

    // Splits an operand into sign and magnitude. Unsigned operands always
    // report a positive sign so callers can XOR signs without special cases.
    function automatic abs_sign_t abs_and_sign(input logic [31:0] value,
                                               input logic        is_signed);
        abs_sign_t r;
        r.neg = is_signed & value[31];
        r.mag = r.neg ? (~value + 32'd1) : value;
        return r;
    endfunction

    // rs1 is signed for MULH, MULHSU, DIV and REM.
    function automatic logic a_is_signed(input funct3_e op);
        return (op == MULH_OP) || (op == MULHSU_OP) ||
               (op == DIV_OP)  || (op == REM_OP);
    endfunction

    // rs2 is signed for MULH, DIV and REM.
    function automatic logic b_is_signed(input funct3_e op);
        return (op == MULH_OP) || (op == DIV_OP) || (op == REM_OP);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// ----------------------------------------------------------------------------
// muldiv_if
//   Request/response bundle between the EX stage and the multiply/divide unit.
//   Ports (master = pipeline side, slave = muldiv_unit):
//     start, Funct3, SrcA, SrcB, flush : master -> slave
//     busy, done, Result               : slave  -> master
// ----------------------------------------------------------------------------
interface muldiv_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [2:0]            Funct3;
    logic [DATA_WIDTH-1:0] SrcA;
    logic [DATA_WIDTH-1:0] SrcB;
    logic                  flush;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] Result;

    modport master (
        output start, Funct3, SrcA, SrcB, flush,
        input  busy, done, Result
    );

    modport slave (
        input  start, Funct3, SrcA, SrcB, flush,
        output busy, done, Result
    );
endinterface

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide unit sitting beside the ALU in EX.
//   Multiply: 32-step shift-add on magnitudes, product negated at the end.
//   Divide  : 32-step restoring division on magnitudes, signs fixed at the end.
//   Divide-by-zero and signed overflow finish in one cycle without iterating.
//   Ports:
//     clk    : rising-edge clock
//     reset  : synchronous active-high reset
//     bus    : muldiv_if.slave (start/Funct3/SrcA/SrcB/flush in,
//              busy/done/Result out). busy is high in MUL/DIV, done is a
//              one-cycle registered pulse, Result is held until the next
//              accepted start.
// ----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    localparam int DW    = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    state_e            state, state_next;
    logic [CNT_W-1:0]  cnt;
    funct3_e           op;          // latched operation
    logic              neg;         // final result must be negated
    logic [DW-1:0]     opnd;        // multiplicand / divisor magnitude
    logic [2*DW-1:0]   acc;         // {product hi, multiplier} or {remainder, quotient}
    logic [DW-1:0]     result_q;
    logic              done_q;
    logic              busy;
    logic              accept;

    // ---------------- request decode ----------------
    funct3_e   in_op;
    abs_sign_t a_abs, b_abs;
    logic      div_by_zero, overflow, special;
    logic [DW-1:0] special_value;

    assign in_op       = funct3_e'(bus.Funct3);
    assign a_abs       = abs_and_sign(bus.SrcA, a_is_signed(in_op));
    assign b_abs       = abs_and_sign(bus.SrcB, b_is_signed(in_op));
    assign div_by_zero = (bus.SrcB == '0);
    assign overflow    = ((in_op == DIV_OP) || (in_op == REM_OP)) &&
                         (bus.SrcA == {1'b1, {(DW-1){1'b0}}}) &&
                         (bus.SrcB == '1);
    assign special     = in_op[2] && (div_by_zero || overflow);

    // in_op[1] selects the remainder flavour among the divide ops.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        special_value = '0;
        if (div_by_zero)
            special_value = in_op[1] ? bus.SrcA : '1;
        else if (overflow)
            special_value = in_op[1] ? '0 : {1'b1, {(DW-1){1'b0}}};
    end

    // ---------------- iteration step ----------------
    logic [DW:0]     mul_sum;
    logic [2*DW-1:0] mul_next, mul_prod;
    logic [DW:0]     div_shifted;
    logic            div_fits;
    logic [DW-1:0]   div_diff;
    logic [2*DW-1:0] div_next;
    logic [DW-1:0]   mul_result, div_raw, div_result;
    logic            last_iter;

    // Shift-add: conditionally add the multiplicand to the upper half, then
    // shift the 65-bit {carry, acc} right by one.
    assign mul_sum  = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, acc[DW-1:1]};

    // Restoring divide: shift {remainder, quotient} left, try to subtract.
    // The shifted remainder can be 33 bits wide; after a successful subtract
    // it always fits back into 32.
    assign div_shifted = acc[2*DW-1:DW-1];
    assign div_fits    = (div_shifted >= {1'b0, opnd});
    assign div_diff    = div_shifted[DW-1:0] - opnd;
    assign div_next    = div_fits ? {div_diff,            acc[DW-2:0], 1'b1}
                                  : {div_shifted[DW-1:0], acc[DW-2:0], 1'b0};

    assign mul_prod   = neg ? (~mul_next + 1'b1) : mul_next;
    assign mul_result = (op == MUL_OP) ? mul_prod[DW-1:0] : mul_prod[2*DW-1:DW];
    assign div_raw    = op[1] ? div_next[2*DW-1:DW] : div_next[DW-1:0];
    assign div_result = neg ? (~div_raw + 1'b1) : div_raw;

    assign last_iter  = (cnt == CNT_W'(ITERATIONS - 1));
    assign accept     = bus.start && !bus.flush &&
                        ((state == IDLE) || (state == DONE));

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (accept)
                    state_next = special ? DONE : (in_op[2] ? DIV : MUL);
            end
            MUL, DIV: begin
                busy = 1'b1;
                if (last_iter)
                    state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
        // Flush wins over both a new request and an ongoing iteration.
        if (bus.flush)
            state_next = IDLE;
    end

    // ---------------- control registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state_next == DONE);
            if (accept) begin
                cnt <= '0;
                if (special)
                    result_q <= special_value;
            end else if (busy && !bus.flush) begin
                cnt <= cnt + CNT_W'(1);
                if (last_iter)
                    result_q <= (state == MUL) ? mul_result : div_result;
            end
        end
    end

    // ---------------- datapath registers ----------------
    // NOTE: operand/accumulator registers carry no reset; they are always
    // loaded on acceptance before being read, which keeps the datapath lean.
    always_ff @(posedge clk) begin
        if (accept) begin
            op  <= in_op;
            // REM/REMU take the dividend sign; everything else XORs signs
            // (unsigned operands report positive, so this covers all ops).
            neg <= (in_op[2] && in_op[1]) ? a_abs.neg : (a_abs.neg ^ b_abs.neg);
            if (in_op[2]) begin
                acc  <= {{DW{1'b0}}, a_abs.mag};
                opnd <= b_abs.mag;
            end else begin
                acc  <= {{DW{1'b0}}, b_abs.mag};
                opnd <= a_abs.mag;
            end
        end else if (busy && !bus.flush) begin
            acc <= (state == MUL) ? mul_next : div_next;
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done_q;
    assign bus.Result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed bench for muldiv_unit. The driver pushes {expected Result,
//   expected done cycle} into a scoreboard when it issues an operation; a
//   separate monitor pops and compares on every done pulse.
//   Cycle numbering: the cycle in which start is driven is cycle 0.
// ----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] value;
        int          cycle;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [31:0] last_result = 32'd0;

    muldiv_if #(.DATA_WIDTH(32)) bus ();

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // Called right after a negedge: drives one start cycle, records the
    // expected response, and returns at the following negedge (cycle 1).
    task automatic issue(input funct3_e f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_val,
                         input int lat, input bit expect_done);
        exp_t e;
        bus.start  = 1'b1;
        bus.Funct3 = f;
        bus.SrcA   = a;
        bus.SrcB   = b;
        if (expect_done) begin
            e.value = exp_val;
            e.cycle = cyc + lat;
            sb.push_back(e);
            last_result = exp_val;
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done)
            check("done_timeout", 32'(bus.done), 32'd1);
    endtask

    // Monitor: every done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(bus.done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("result", bus.Result, mon_e.value);
                check("done_cycle", 32'(cyc), 32'(mon_e.cycle));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.Funct3 = 3'b000;
        bus.SrcA   = '0;
        bus.SrcB   = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",   32'(bus.busy), 32'd0);
        check("rst_done",   32'(bus.done), 32'd0);
        check("rst_result", bus.Result,    32'd0);
        reset = 1'b0;

        // 1. MUL 7 x -3 with busy profile
        @(negedge clk);
        issue(MUL_OP, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1);
        for (int k = 1; k <= 32; k++) begin
            check("mul_busy", 32'(bus.busy), 32'd1);
            @(negedge clk);
        end
        check("mul_busy_done", 32'(bus.busy), 32'd0);
        wait_done();

        // 2. upper-half multiplies
        @(negedge clk); issue(MULHU_OP,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1); wait_done();
        @(negedge clk); issue(MULH_OP,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1); wait_done();
        @(negedge clk); issue(MULHSU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1); wait_done();

        // 3. divides
        @(negedge clk); issue(DIV_OP,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1); wait_done();
        @(negedge clk); issue(REM_OP,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1); wait_done();
        @(negedge clk); issue(DIVU_OP, 32'd100,       32'd7, 32'd14,        33, 1); wait_done();
        @(negedge clk); issue(REMU_OP, 32'd100,       32'd7, 32'd2,         33, 1); wait_done();

        // 4. special divide cases (single cycle)
        @(negedge clk); issue(DIV_OP,  32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1); wait_done();
        @(negedge clk); issue(REMU_OP, 32'd5, 32'd0, 32'd5,         1, 1); wait_done();
        @(negedge clk); issue(DIV_OP,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1); wait_done();
        @(negedge clk); issue(REM_OP,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1); wait_done();

        // 5a. start while busy is ignored
        @(negedge clk);
        issue(DIVU_OP, 32'd100, 32'd7, 32'd14, 33, 1);
        repeat (4) @(negedge clk);
        bus.start  = 1'b1;
        bus.Funct3 = MUL_OP;
        bus.SrcA   = 32'd3;
        bus.SrcB   = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();

        // 5b. flush in cycle 10
        @(negedge clk);
        issue(DIV_OP, 32'd1000, 32'd3, 32'd0, 33, 0);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy",   32'(bus.busy), 32'd0);
        check("flush_done",   32'(bus.done), 32'd0);
        check("flush_result", bus.Result,    last_result);
        repeat (40) @(negedge clk);
        check("flush_idle_busy", 32'(bus.busy), 32'd0);

        // 5c. back-to-back: start held in the DONE cycle
        @(negedge clk);
        issue(MUL_OP, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1);
        repeat (32) @(negedge clk);
        check("b2b_done_first", 32'(bus.done), 32'd1);
        issue(REMU_OP, 32'd100, 32'd7, 32'd2, 33, 1);
        wait_done();

        // 6. reset in cycle 15 of a DIV
        @(negedge clk);
        issue(DIV_OP, 32'd1000, 32'd3, 32'd0, 33, 0);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy",   32'(bus.busy), 32'd0);
        check("mid_rst_done",   32'(bus.done), 32'd0);
        check("mid_rst_result", bus.Result,    32'd0);
        @(negedge clk);
        issue(MUL_OP, 32'd3, 32'd4, 32'd12, 33, 1);
        wait_done();

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
